// File: rtl/bcd_digit_formatter.sv
// bcd_digit_formatter
//   Converts an unsigned binary value into four 5-bit digit codes for a
//   4-digit 7-segment controller. The conversion is iterative double dabble:
//   the value is shifted in one bit per clock.
//   Leading zeros can be blanked. Values above 9999 show as four dashes.
//   Results are registered and held until the next conversion completes.
//
// Ports
//   clk       in   1      system clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      begin conversion of value (only sampled in IDLE)
//   value     in   WIDTH  unsigned binary value
//   busy      out  1      conversion in progress
//   done      out  1      one-cycle pulse when d0..d3/overflow are updated
//   overflow  out  1      last converted value was > 9999
//   d0..d3    out  5      digit codes, ones (d0) to thousands (d3)
module bcd_digit_formatter #(
    parameter int WIDTH         = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [4:0]       d0,
    output logic [4:0]       d1,
    output logic [4:0]       d2,
    output logic [4:0]       d3
);

    localparam int SW = WIDTH + 20;          // 5 BCD nibbles above the binary field
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FORMAT = 2'd2;

    localparam logic [4:0] CODE_DASH  = 5'd22;
    localparam logic [4:0] CODE_BLANK = 5'd23;

    logic [1:0]    state;
    logic [SW-1:0] sr;
    logic [SW-1:0] sr_adj;
    logic [CW-1:0] cnt;

    // Add-3 correction on each BCD nibble before the shift. Each nibble is
    // corrected independently; no carry crosses nibble boundaries.
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < 5; k++) begin
            if (sr[WIDTH + 4*k +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*k +: 4] = sr[WIDTH + 4*k +: 4] + 4'd3;
        end
    end

    // Final BCD nibbles once all WIDTH bits have been shifted in.
    logic [3:0] t_n, b3, b2, b1, b0;
    logic       blank3, blank2, blank1;

    always_comb begin
        t_n = sr[WIDTH + 16 +: 4];
        b3  = sr[WIDTH + 12 +: 4];
        b2  = sr[WIDTH +  8 +: 4];
        b1  = sr[WIDTH +  4 +: 4];
        b0  = sr[WIDTH      +: 4];
        // A digit is blanked only if it and every digit to its left are zero.
        blank3 = BLANK_LEADING && (b3 == 4'd0);
        blank2 = blank3 && (b2 == 4'd0);
        blank1 = blank2 && (b1 == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            sr       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            d0       <= CODE_BLANK;
            d1       <= CODE_BLANK;
            d2       <= CODE_BLANK;
            d3       <= CODE_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr    <= {20'b0, value};
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr  <= {sr_adj[SW-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= S_FORMAT;
                end
                S_FORMAT: begin
                    if (t_n != 4'd0) begin
                        overflow <= 1'b1;
                        d3 <= CODE_DASH;
                        d2 <= CODE_DASH;
                        d1 <= CODE_DASH;
                        d0 <= CODE_DASH;
                    end else begin
                        overflow <= 1'b0;
                        d3 <= blank3 ? CODE_BLANK : {1'b0, b3};
                        d2 <= blank2 ? CODE_BLANK : {1'b0, b2};
                        d1 <= blank1 ? CODE_BLANK : {1'b0, b1};
                        d0 <= {1'b0, b0};
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Testbench for bcd_digit_formatter (WIDTH = 14, BLANK_LEADING = 1).
// Stimulus pushes hand-computed expected results {overflow,d3,d2,d1,d0}
// into a queue; a monitor pops and compares on every done pulse.
module tb_bcd_digit_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] value;
    logic        busy, done, overflow;
    logic [4:0]  d0, d1, d2, d3;

    int vectors = 0;
    int miscompares = 0;
    logic [20:0] exp_q[$];

    bcd_digit_formatter #(.WIDTH(14), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .overflow(overflow),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [20:0] e(input logic ov, input logic [4:0] a3, input logic [4:0] a2,
                                      input logic [4:0] a1, input logic [4:0] a0);
        return {ov, a3, a2, a1, a0};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [20:0] exp;
                exp = exp_q.pop_front();
                check("result", {11'd0, overflow, d3, d2, d1, d0}, {11'd0, exp});
            end
        end
    end

    // One conversion; checks busy after accept and done latency (15 edges).
    // If poke is set, a second start with value 99 is issued at edge N+5.
    task automatic convert(input logic [13:0] v, input logic [20:0] exp, input bit poke);
        bit seen = 0;
        @(negedge clk);
        value = v; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);                      // edge N: accepted
        #1 start = 1'b0; value = ~v;         // value changes while busy must not matter
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke && n == 4) begin start = 1'b1; value = 14'd99; end
            if (poke && n == 5) start = 1'b0;
            if (done) begin
                seen = 1;
                check("done_latency", n, 32'd15);
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; value = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out", {11'd0, overflow, d3, d2, d1, d0}, {11'd0, e(0, 23, 23, 23, 23)});

        convert(14'd1234,  e(0, 1, 2, 3, 4),     0);
        convert(14'd7,     e(0, 23, 23, 23, 7),  0);
        convert(14'd0,     e(0, 23, 23, 23, 0),  0);
        convert(14'd1005,  e(0, 1, 0, 0, 5),     0);
        convert(14'd100,   e(0, 23, 1, 0, 0),    0);
        convert(14'd10000, e(1, 22, 22, 22, 22), 0);
        convert(14'd9999,  e(0, 9, 9, 9, 9),     0);
        convert(14'd16383, e(1, 22, 22, 22, 22), 0);
        convert(14'd42,    e(0, 23, 23, 4, 2),   1);

        // Held outputs between conversions
        repeat (3) @(negedge clk);
        check("hold_out", {11'd0, overflow, d3, d2, d1, d0}, {11'd0, e(0, 23, 23, 4, 2)});

        // Reset mid-conversion: start at edge N, reset at edge N+8.
        @(negedge clk);
        value = 14'd9876; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out", {11'd0, overflow, d3, d2, d1, d0}, {11'd0, e(0, 23, 23, 23, 23)});
        begin
            bit any_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (done) any_done = 1;
            end
            check("abort_no_done", {31'd0, any_done}, 32'd0);
        end

        // Back-to-back with start held high: accepts at N, N+16, N+32.
        begin
            int hits[$];
            @(negedge clk);
            value = 14'd1; start = 1'b1;
            exp_q.push_back(e(0, 23, 23, 23, 1));
            exp_q.push_back(e(0, 23, 23, 23, 2));
            exp_q.push_back(e(0, 23, 23, 23, 3));
            @(posedge clk);                  // edge N
            #1 value = 14'd2;
            for (int n = 1; n <= 60; n++) begin
                @(posedge clk);
                if (n == 16) #1 value = 14'd3;
                if (n == 32) #1 start = 1'b0;
                @(negedge clk);
                if (done) hits.push_back(n);
            end
            check("b2b_count", hits.size(), 32'd3);
            if (hits.size() == 3) begin
                check("b2b_done0", hits[0], 32'd15);
                check("b2b_done1", hits[1], 32'd31);
                check("b2b_done2", hits[2], 32'd47);
            end
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
